// File: rtl/vc_swap_ctrl_pkg.sv
// Shared lc3b types and constants for the victim cache controller.
// The optional VC_PERF_CNT_EN build adds hit/miss counters to vc_swap_ctrl.
package lc3b_types;

  localparam int NUM_WAYS = 8;
  localparam int LINE_W   = 256;
  localparam int TAG_W    = 11;

  typedef logic [15:0]       lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [TAG_W-1:0]  lc3b_tag;
  typedef logic [2:0]        vc_way_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    FETCH = 2'd2,
    RESP  = 2'd3
  } vc_state_t;

  // Stack {7,6,5,4,3,2,1,0}: MRU in [23:21], LRU in [2:0].
  localparam logic [23:0] VC_LRU_RESET = 24'hFAC688;

  function automatic lc3b_word line_addr(input lc3b_tag tag);
    return {tag, 5'b0};
  endfunction

endpackage

// File: rtl/vc_swap_ctrl_lru.sv
// LRU stack updater: moves the accessed way to the MRU slot and shifts the
// entries that were above it down by one.
module VC_LRU_stack
  import lc3b_types::*;
(
  input  logic [23:0] old_LRU,
  input  vc_way_t     way,
  output logic [23:0] new_LRU
);

  logic [2:0] pos;

  always_comb begin
    // A way already at MRU (or absent) leaves pos at 7, so nothing shifts.
    pos = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (old_LRU[i*3 +: 3] == way) pos = 3'(i);
    end
    new_LRU = old_LRU;
    for (int i = 0; i < 7; i++) begin
      if (3'(i) >= pos) new_LRU[i*3 +: 3] = old_LRU[(i+1)*3 +: 3];
    end
    new_LRU[23:21] = way;
  end

endmodule

// File: rtl/vc_swap_ctrl.sv
// 8-way exclusive victim cache controller between L1 and memory.
// Define VC_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
// Handshake: l1_req is held with stable fields until the one-cycle l1_resp;
// mem_read/mem_write are held until the one-cycle mem_resp.
module vc_swap_ctrl
  import lc3b_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              l1_req,
  input  logic [TAG_W-1:0]  l1_req_tag,
  input  logic              l1_vic_valid,
  input  logic              l1_vic_dirty,
  input  logic [TAG_W-1:0]  l1_vic_tag,
  input  logic [LINE_W-1:0] l1_vic_data,
  output logic              l1_resp,
  output logic [LINE_W-1:0] l1_rdata,
  output logic              l1_rdirty,
  output logic              mem_read,
  output logic              mem_write,
  output logic [15:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
`ifdef VC_PERF_CNT_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  output vc_state_t         dbg_state
);

  vc_state_t             state;
  logic [23:0]           lru_q;
  logic [23:0]           lru_next;
  lc3b_tag               tag_q  [NUM_WAYS];
  lc3b_line              data_q [NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_q;
  logic [NUM_WAYS-1:0]   dirty_q;
  vc_way_t               ins_way_q;
  vc_way_t               hit_way;
  vc_way_t               upd_way;
  vc_way_t               lru_way;
  logic                  hit;

  assign lru_way   = lru_q[2:0];
  assign dbg_state = state;

  // Lowest matching way wins; exclusivity means at most one should match.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = NUM_WAYS-1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == l1_req_tag) begin
        hit     = 1'b1;
        hit_way = 3'(i);
      end
    end
  end

  // Only IDLE updates with the hit way; every other update is the insert way.
  assign upd_way = (state == IDLE) ? hit_way : ins_way_q;

  VC_LRU_stack u_lru (
    .old_LRU (lru_q),
    .way     (upd_way),
    .new_LRU (lru_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      lru_q     <= VC_LRU_RESET;
      ins_way_q <= '0;
      l1_resp   <= 1'b0;
      l1_rdata  <= '0;
      l1_rdirty <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (l1_req) begin
            if (hit) begin
              l1_rdata         <= data_q[hit_way];
              l1_rdirty        <= dirty_q[hit_way];
              tag_q[hit_way]   <= l1_vic_tag;
              data_q[hit_way]  <= l1_vic_data;
              valid_q[hit_way] <= l1_vic_valid;
              dirty_q[hit_way] <= l1_vic_dirty;
              lru_q            <= lru_next;
              l1_resp          <= 1'b1;
              state            <= RESP;
            end else begin
              ins_way_q <= lru_way;
              if (valid_q[lru_way] && dirty_q[lru_way]) begin
                mem_write <= 1'b1;
                mem_addr  <= line_addr(tag_q[lru_way]);
                mem_wdata <= data_q[lru_way];
                state     <= WB;
              end else begin
                mem_read <= 1'b1;
                mem_addr <= line_addr(l1_req_tag);
                state    <= FETCH;
              end
            end
          end
        end
        WB: begin
          // Write drops on the same edge read rises, so they never overlap.
          if (mem_resp) begin
            mem_write          <= 1'b0;
            valid_q[ins_way_q] <= 1'b0;
            mem_read           <= 1'b1;
            mem_addr           <= line_addr(l1_req_tag);
            state              <= FETCH;
          end
        end
        FETCH: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            l1_rdata  <= mem_rdata;
            l1_rdirty <= 1'b0;
            l1_resp   <= 1'b1;
            state     <= RESP;
            if (l1_vic_valid) begin
              tag_q[ins_way_q]   <= l1_vic_tag;
              data_q[ins_way_q]  <= l1_vic_data;
              valid_q[ins_way_q] <= 1'b1;
              dirty_q[ins_way_q] <= l1_vic_dirty;
              lru_q              <= lru_next;
            end
          end
        end
        RESP: begin
          l1_resp <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE && l1_req) begin
      if (hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vc_swap_ctrl.sv
// Bench for vc_swap_ctrl: directed scenarios plus randomized traffic checked
// against a way-array/recency-list model of the victim cache.
module tb_vc_swap_ctrl;
  import lc3b_types::*;

  localparam int W = LINE_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              l1_req = 1'b0;
  logic [TAG_W-1:0]  l1_req_tag = '0;
  logic              l1_vic_valid = 1'b0;
  logic              l1_vic_dirty = 1'b0;
  logic [TAG_W-1:0]  l1_vic_tag = '0;
  logic [LINE_W-1:0] l1_vic_data = '0;
  logic              l1_resp;
  logic [LINE_W-1:0] l1_rdata;
  logic              l1_rdirty;
  logic              mem_read;
  logic              mem_write;
  logic [15:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_resp = 1'b0;
  vc_state_t         dbg_state;
`ifdef VC_PERF_CNT_EN
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;
`endif

  vc_swap_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .l1_req       (l1_req),
    .l1_req_tag   (l1_req_tag),
    .l1_vic_valid (l1_vic_valid),
    .l1_vic_dirty (l1_vic_dirty),
    .l1_vic_tag   (l1_vic_tag),
    .l1_vic_data  (l1_vic_data),
    .l1_resp      (l1_resp),
    .l1_rdata     (l1_rdata),
    .l1_rdirty    (l1_rdirty),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
`ifdef VC_PERF_CNT_EN
    .hit_count    (hit_count),
    .miss_count   (miss_count),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [W-1:0] exp_q[$];
  lc3b_tag     m_tag   [8];
  lc3b_line    m_data  [8];
  bit          m_valid [8];
  bit          m_dirty [8];
  int          recency[$];   // way numbers, most recent first
  int          m_hits;
  int          m_misses;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    recency = {7, 6, 5, 4, 3, 2, 1, 0};
    m_hits   = 0;
    m_misses = 0;
    exp_q.delete();
  endtask

  task automatic touch(input int w);
    for (int i = 0; i < recency.size(); i++) begin
      if (recency[i] == w) begin
        recency.delete(i);
        break;
      end
    end
    recency.push_front(w);
  endtask

  function automatic logic [23:0] model_lru();
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[23-3*i -: 3] = 3'(recency[i]);
    return v;
  endfunction

  function automatic lc3b_line rand_line();
    lc3b_line v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit tag_in_model(input lc3b_tag t);
    for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == t) return 1;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; l1_req = 1'b0; mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_req(input lc3b_tag tag, input bit vv, input bit vd,
                        input lc3b_tag vtag, input lc3b_line vdata);
    int hw, lw, cycles, dly;
    bit exp_wb, exp_rd, exp_dirty, got, saw_rd, saw_wr;
    lc3b_word wb_addr;
    lc3b_line wb_data, fetch_data;
    hw = -1; lw = 0; exp_wb = 0; wb_addr = '0; wb_data = '0;
    fetch_data = rand_line();
    for (int i = 0; i < 8; i++) if (hw < 0 && m_valid[i] && m_tag[i] == tag) hw = i;
    if (hw >= 0) begin
      exp_rd = 0;
      exp_q.push_back(m_data[hw]);
      exp_dirty  = m_dirty[hw];
      m_tag[hw]  = vtag; m_data[hw] = vdata; m_valid[hw] = vv; m_dirty[hw] = vd;
      touch(hw);
      m_hits++;
    end else begin
      exp_rd  = 1;
      lw      = recency[$];
      exp_wb  = m_valid[lw] && m_dirty[lw];
      wb_addr = {m_tag[lw], 5'b0};
      wb_data = m_data[lw];
      if (exp_wb) m_valid[lw] = 0;
      exp_q.push_back(fetch_data);
      exp_dirty = 0;
      if (vv) begin
        m_tag[lw] = vtag; m_data[lw] = vdata; m_valid[lw] = 1; m_dirty[lw] = vd;
        touch(lw);
      end
      m_misses++;
    end

    @(negedge clk);
    l1_req = 1'b1; l1_req_tag = tag; l1_vic_valid = vv; l1_vic_dirty = vd;
    l1_vic_tag = vtag; l1_vic_data = vdata; mem_rdata = fetch_data;
    cycles = 0; dly = -1; got = 0; saw_rd = 0; saw_wr = 0;
    while (!got && cycles < 300) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      mem_resp = 1'b0;
      if (mem_read && mem_write) check("mem_overlap", W'(mem_read & mem_write), W'(0));
      if (l1_resp) begin
        got = 1;
        check("rdata", l1_rdata, exp_q.pop_front());
        check("rdirty", W'(l1_rdirty), W'(exp_dirty));
        if (hw >= 0) check("hit_latency", W'(cycles), W'(1));
        check("wb_seen", W'(saw_wr), W'(exp_wb));
        check("rd_seen", W'(saw_rd), W'(exp_rd));
        l1_req = 1'b0;
      end else if (mem_read || mem_write) begin
        if (dly < 0) begin
          if (mem_write) begin
            saw_wr = 1;
            check("wb_expected", W'(mem_write), W'(exp_wb));
            check("wb_before_rd", W'(saw_rd), W'(0));
            check("wb_addr", W'(mem_addr), W'(wb_addr));
            check("wb_data", mem_wdata, wb_data);
          end else begin
            saw_rd = 1;
            check("rd_expected", W'(mem_read), W'(exp_rd));
            check("rd_addr", W'(mem_addr), W'({tag, 5'b0}));
          end
          dly = $urandom_range(0, 3);
        end
        if (dly == 0) begin
          mem_resp = 1'b1;
          dly = -1;
        end else begin
          dly--;
        end
      end
    end
    if (!got) begin
      check("timeout", W'(got), W'(1));
      l1_req = 1'b0;
      void'(exp_q.pop_front());
    end
    check("lru", W'(dut.lru_q), W'(model_lru()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    lc3b_line line_a, line_b;
    lc3b_tag  t, vt;
    int       tries, mr_cycles;
    bit       stray_resp;

    model_reset();
    reset_dut();
    check("rst_resp", W'(l1_resp), W'(0));
    check("rst_mem_read", W'(mem_read), W'(0));
    check("rst_mem_write", W'(mem_write), W'(0));
    check("rst_rdata", l1_rdata, W'(0));
    check("rst_wdata", mem_wdata, W'(0));
    check("rst_state", W'(dbg_state), W'(IDLE));
    check("rst_lru", W'(dut.lru_q), W'(24'hFAC688));

    // Cold miss with no victim: plain fetch, LRU untouched.
    do_req(11'h012, 0, 0, 11'h000, '0);
    check("cold_lru", W'(dut.lru_q), W'(24'hFAC688));

    // Insert dirty victim into way 0, then hit it with a swap.
    line_a = rand_line();
    line_b = rand_line();
    do_req(11'h012, 1, 1, 11'h034, line_a);
    check("insert_lru", W'(dut.lru_q), W'(24'h1F58D1));
    do_req(11'h034, 1, 0, 11'h056, line_b);
    check("swap_tag", W'(dut.tag_q[0]), W'(11'h056));

    // Hit with an invalid victim empties the way; repeat then misses.
    do_req(11'h056, 0, 0, 11'h000, '0);
    do_req(11'h056, 0, 0, 11'h000, '0);

    // Fill all ways dirty, then force a writeback of the LRU way.
    reset_dut();
    for (int i = 0; i < 8; i++) do_req(11'h200 + 11'(i), 1, 1, 11'h100 + 11'(i), rand_line());
    do_req(11'h1FF, 1, 1, 11'h1FE, rand_line());
    do_req(11'h1FD, 1, 0, 11'h1FC, rand_line());

    // Reset while a fetch is outstanding aborts everything.
    reset_dut();
    @(negedge clk);
    l1_req = 1'b1; l1_req_tag = 11'h077; l1_vic_valid = 1'b1;
    l1_vic_dirty = 1'b1; l1_vic_tag = 11'h078; l1_vic_data = rand_line();
    mr_cycles = 0;
    while (!mem_read && mr_cycles < 20) begin
      @(negedge clk);
      mr_cycles++;
    end
    check("midfetch_read", W'(mem_read), W'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_read", W'(mem_read), W'(0));
    check("abort_resp", W'(l1_resp), W'(0));
    check("abort_valid", W'(dut.valid_q), W'(0));
    check("abort_lru", W'(dut.lru_q), W'(24'hFAC688));
    rst = 1'b0;
    l1_req = 1'b0;
    model_reset();
    stray_resp = 0;
    repeat (5) begin
      @(negedge clk);
      if (l1_resp || mem_read || mem_write) stray_resp = 1;
    end
    check("abort_quiet", W'(stray_resp), W'(0));

    // Randomized traffic over a small tag pool so hits are frequent.
    for (int n = 0; n < 150; n++) begin
      t = 11'h040 + 11'($urandom_range(0, 15));
      vt = t;
      tries = 0;
      while ((vt == t || tag_in_model(vt)) && tries < 100) begin
        vt = 11'h040 + 11'($urandom_range(0, 15));
        tries++;
      end
      do_req(t, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, vt, rand_line());
    end

`ifdef VC_PERF_CNT_EN
    check("hit_count", W'(hit_count), W'(m_hits));
    check("miss_count", W'(miss_count), W'(m_misses));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vc_swap_ctrl.md
Name: vc_swap_ctrl

Overview:
- Controller and storage for an 8-entry, fully associative, exclusive victim cache between the L1 data cache and physical memory (L2/pmem) in the lc3b pipeline.
- Owns the 24-bit LRU stack register and the per-way tag, data, valid and dirty arrays.
- Services each L1 miss:
  - On a VC hit, it swaps the L1's evicted line with the hit line.
  - On a VC miss, it fetches the line from memory and inserts the L1's evicted line into the LRU way. Before that insert, it writes back the LRU way if it is dirty.

Parameters:
- NUM_WAYS, 8, number of victim ways. Fixed at 8 by the 3-bit way encoding of the LRU stack.
- LINE_W, 256, line width in bits.
- TAG_W, 11, line tag width: addr[15:5] of the 16-bit lc3b address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- l1_req  in  1  L1 miss request. Held high with all request fields stable until l1_resp.
- l1_req_tag  in  TAG_W  tag of the missing line
- l1_vic_valid  in  1  L1 supplies an evicted line with this request
- l1_vic_dirty  in  1  dirty bit of the evicted line
- l1_vic_tag  in  TAG_W  tag of the evicted line
- l1_vic_data  in  LINE_W  data of the evicted line
- l1_resp  out  1  one-cycle pulse: l1_rdata and l1_rdirty are valid
- l1_rdata  out  LINE_W  returned line
- l1_rdirty  out  1  dirty bit of the returned line. 0 when the line was fetched from memory.
- mem_read  out  1  memory read request, held until mem_resp
- mem_write  out  1  memory write request, held until mem_resp
- mem_addr  out  16  {tag, 5'b0}
- mem_wdata  out  LINE_W  writeback data
- mem_rdata  in  LINE_W  fetched data
- mem_resp  in  1  memory completion pulse

Behaviour:
- **Reset** (synchronous, rst=1 at a clk edge):
  - All valid and dirty bits cleared; state set to IDLE.
  - LRU register set to 24'hFAC688, i.e. {7,6,5,4,3,2,1,0}. MRU is bits [23:21]; LRU way is bits [2:0].
  - l1_resp, mem_read and mem_write set to 0; l1_rdata and mem_wdata set to 0.
  - Reset asserted mid-operation aborts any transaction. Memory requests drop in the same cycle as the reset edge, and no array write occurs.
- **LRU update:** next_LRU = stack_update(LRU, way).
  - The accessed way moves to [23:21]; entries above its old position shift down one slot.
  - A way already at MRU leaves the register unchanged.
- **IDLE state:**
  - Tag compare of l1_req_tag against all valid ways is combinational. Hit way = lowest index on match; more than one match is illegal because the cache is exclusive.
  - l1_req and hit -> RESP. At the edge:
    - l1_rdata/l1_rdirty latched from the hit way.
    - The hit way is overwritten with the L1 victim (valid = l1_vic_valid).
    - LRU updated with the hit way, even if the victim is invalid.
    - Latency: l1_resp high in the cycle after the request is seen.
  - l1_req and miss -> WB if LRU way [2:0] is valid & dirty; otherwise -> FETCH.
- **WB state:**
  - mem_write=1, mem_addr={LRU-way tag,5'b0}, mem_wdata=LRU-way data.
  - On mem_resp: clear that way's valid bit, -> FETCH.
- **FETCH state:**
  - mem_read=1, mem_addr={l1_req_tag,5'b0}.
  - On mem_resp: latch mem_rdata into l1_rdata, l1_rdirty=0, -> RESP.
  - At the same edge, if l1_vic_valid: write the victim into the LRU way captured at request time, set valid, copy the dirty bit, and update LRU with that way.
  - If l1_vic_valid=0: no insert, LRU unchanged.
- **RESP state:** l1_resp=1 for exactly one cycle, -> IDLE. A new l1_req is accepted no earlier than the following cycle.
- mem_read and mem_write are never asserted together.
- l1_req while the controller is not in IDLE is ignored; the L1 holds it.
- mem_resp outside WB or FETCH is ignored.

Optional Feature:
- Macro: VC_PERF_CNT_EN.
- Defined:
  - Adds output ports hit_count[31:0] and miss_count[31:0], reset to 0.
  - hit_count increments on each IDLE hit; miss_count increments on each IDLE miss.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: no ports, no counter logic.

Decomposition:
- lc3b_types package: lc3b_word (16-bit address), a 256-bit line type, an 11-bit tag type, and a vc_state_t enum {IDLE, WB, FETCH, RESP}. Add a constant VC_LRU_RESET = 24'hFAC688.
- Sub-module: instantiate the existing VC_LRU_stack updater (old_LRU, way -> new_LRU). Use one instance and mux its way input (hit way or insert way); do not duplicate the logic.

Test Plan:
- **Reset then lookup:** reset, l1_req tag 0x012 with no victim -> mem_read, mem_addr 0x0240. After mem_resp with data D: l1_resp with l1_rdata=D, l1_rdirty=0; LRU still FAC688.
- **Insert then hit swap:**
  - Miss for tag 0x012 with victim tag 0x034 (dirty, data A) -> A stored in way 0; LRU=0x1F58D1, i.e. {0,7,6,5,4,3,2,1}.
  - Then request tag 0x034 with victim tag 0x056 (clean, data B) -> l1_resp next cycle with rdata=A, rdirty=1, no memory traffic; way 0 now holds tag 0x056.
- **Dirty writeback:** fill all 8 ways with dirty victims, then miss on a new tag -> mem_write of the LRU way at {tag,5'b0}, then mem_read, then insert into that way. Check the mem_write/mem_read order and that they never overlap.
- **Invalid victim on hit:** hit with l1_vic_valid=0 -> hit way becomes invalid; a repeat request for the same tag misses.
- **Reset mid-fetch:** assert rst while in FETCH before mem_resp -> mem_read low after the edge, all ways invalid, LRU=FAC688, no l1_resp.
- **Counters (VC_PERF_CNT_EN):** 3 hits and 2 misses -> hit_count=3, miss_count=2. Preload 32'hFFFFFFFF and hit -> hit_count stays at saturation.
